// File: rtl/timing_decoder.sv
// timing_decoder: receive-side recovery of 800x600@60 video timing.
// Regenerates pixel/line counters from the blanking strobes of an upstream
// timing source, measures line and frame lengths against the expected totals,
// and reports lock and error status.
//
// Optional feature macro: TIMING_DECODER_SYNC_CHECK_EN
//   defined   - hsync/vsync edges are checked against the expected positions
//   undefined - sync strobes are only forwarded
//
// Ports:
//   pclk, reset_n                         pixel clock, async active-low reset
//   hsync_in, vsync_in, hblnk_in, vblnk_in  upstream timing strobes
//   hsync_out, vsync_out, hblnk_out, vblnk_out  registered copies of the inputs
//   hcount_out, vcount_out                recovered pixel / line counters
//   line_len, frame_len                   length of last line (pixels) / frame (lines)
//   locked                                timing stable and matching
//   err                                   one-cycle pulse on a check failure while locked
//   err_cnt                               saturating error count
module timing_decoder #(
    parameter int unsigned H_TOTAL      = 1056,
    parameter int unsigned V_TOTAL      = 628,
    parameter int unsigned H_SYNC_START = 840,
    parameter int unsigned H_SYNC_WIDTH = 128,
    parameter int unsigned V_SYNC_START = 601,
    parameter int unsigned V_SYNC_WIDTH = 4,
    parameter int unsigned LOCK_FRAMES  = 2
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic [11:0] line_len,
    output logic [11:0] frame_len,
    output logic        locked,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam int unsigned CW = 12;
    localparam int unsigned EW = 8;
    localparam int unsigned GW = 4;

    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [EW-1:0] ERR_MAX   = {EW{1'b1}};
    localparam logic [CW-1:0] H_TOTAL_C = CW'(H_TOTAL);
    localparam logic [CW-1:0] V_TOTAL_C = CW'(V_TOTAL);
    localparam logic [CW-1:0] HS_RISE_C = CW'(H_SYNC_START);
    localparam logic [CW-1:0] HS_FALL_C = CW'(H_SYNC_START + H_SYNC_WIDTH);
    localparam logic [CW-1:0] VS_RISE_C = CW'(V_SYNC_START);
    localparam logic [CW-1:0] VS_FALL_C = CW'(V_SYNC_START + V_SYNC_WIDTH);
    localparam logic [GW-1:0] LOCK_C    = GW'(LOCK_FRAMES);

`ifdef TIMING_DECODER_SYNC_CHECK_EN
    localparam logic SYNC_CHECK = 1'b1;
`else
    localparam logic SYNC_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t        state;
    logic [GW-1:0] good_cnt;
    logic          frame_bad;

    logic          hfall, vfall;
    logic          hs_rise, hs_fall, vs_rise, vs_fall;
    logic [CW-1:0] hcount_inc, vcount_inc, hcount_next, vcount_next;
    logic          watchdog, line_bad, frame_shape_bad;
    logic          sync_mismatch, sync_bad, event_bad;
    logic [GW-1:0] good_inc;
    logic [EW-1:0] err_inc;

    // Edge detection, counter next values and per-cycle check results
    always_comb begin
        hfall   = hblnk_out & ~hblnk_in;
        vfall   = vblnk_out & ~vblnk_in;
        hs_rise = hsync_in & ~hsync_out;
        hs_fall = hsync_out & ~hsync_in;
        vs_rise = vsync_in & ~vsync_out;
        vs_fall = vsync_out & ~vsync_in;

        hcount_inc = (hcount_out == CNT_MAX) ? CNT_MAX : hcount_out + CW'(1);
        vcount_inc = (vcount_out == CNT_MAX) ? CNT_MAX : vcount_out + CW'(1);

        hcount_next = hfall ? '0 : hcount_inc;
        vcount_next = vcount_out;
        if (hfall) begin
            vcount_next = vfall ? '0 : vcount_inc;
        end

        // Fires while the pixel counter is hitting or sitting at saturation
        watchdog        = ~hfall & (hcount_out >= (CNT_MAX - CW'(1)));
        line_bad        = hfall & (hcount_inc != H_TOTAL_C);
        // A vblnk fall not aligned to a line start is a malformed frame
        frame_shape_bad = vfall & (~hfall | (vcount_inc != V_TOTAL_C));

        // Sync edges are compared against the counter value loaded this edge
        sync_mismatch = (hs_rise & (hcount_next != HS_RISE_C))
                      | (hs_fall & (hcount_next != HS_FALL_C))
                      | (vs_rise & (vcount_next != VS_RISE_C))
                      | (vs_fall & (vcount_next != VS_FALL_C));
        sync_bad      = SYNC_CHECK & sync_mismatch;

        event_bad = line_bad | watchdog | sync_bad;
        good_inc  = good_cnt + GW'(1);
        err_inc   = (err_cnt == ERR_MAX) ? ERR_MAX : err_cnt + EW'(1);
    end

    // Stage-1 registers, counters, measurements and lock state machine
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hcount_out <= '0;
            vcount_out <= '0;
            line_len   <= '0;
            frame_len  <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
            state      <= SEARCH;
            good_cnt   <= '0;
            frame_bad  <= 1'b0;
        end else begin
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            hblnk_out  <= hblnk_in;
            vblnk_out  <= vblnk_in;
            hcount_out <= hcount_next;
            vcount_out <= vcount_next;
            err        <= 1'b0;

            if (hfall) begin
                line_len <= hcount_inc;
            end
            if (vfall) begin
                frame_len <= vcount_inc;
            end

            case (state)
                SEARCH: begin
                    if (vfall) begin
                        state     <= ACQUIRE;
                        good_cnt  <= '0;
                        frame_bad <= 1'b0;
                    end
                end
                ACQUIRE: begin
                    if (vfall) begin
                        // Coincident line/sync results count against the closing frame
                        frame_bad <= 1'b0;
                        if (frame_bad | event_bad | frame_shape_bad) begin
                            good_cnt <= '0;
                        end else if (good_inc >= LOCK_C) begin
                            good_cnt <= '0;
                            state    <= LOCKED;
                            locked   <= 1'b1;
                        end else begin
                            good_cnt <= good_inc;
                        end
                    end else if (event_bad) begin
                        frame_bad <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (event_bad | frame_shape_bad) begin
                        err      <= 1'b1;
                        err_cnt  <= err_inc;
                        state    <= SEARCH;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timing_decoder.sv
// Testbench for timing_decoder: a scaled-down timing generator drives the
// decoder; expected strobes/counters are queued when driven and compared when
// the decoder output appears one edge later.
module tb_timing_decoder;

    localparam int H_TOTAL     = 8;
    localparam int H_ACT       = 5;
    localparam int HS_START    = 6;
    localparam int HS_W        = 1;
    localparam int V_TOTAL     = 5;
    localparam int V_ACT       = 2;
    localparam int VS_START    = 3;
    localparam int VS_W        = 1;
    localparam int LOCK_FRAMES = 2;
    localparam int FRAME       = H_TOTAL * V_TOTAL;

    logic        pclk;
    logic        reset_n;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] hcount_out, vcount_out, line_len, frame_len;
    logic        locked, err;
    logic [7:0]  err_cnt;

    timing_decoder #(
        .H_TOTAL     (H_TOTAL),
        .V_TOTAL     (V_TOTAL),
        .H_SYNC_START(HS_START),
        .H_SYNC_WIDTH(HS_W),
        .V_SYNC_START(VS_START),
        .V_SYNC_WIDTH(VS_W),
        .LOCK_FRAMES (LOCK_FRAMES)
    ) dut (
        .pclk      (pclk),
        .reset_n   (reset_n),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .hblnk_in  (hblnk_in),
        .vblnk_in  (vblnk_in),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .hblnk_out (hblnk_out),
        .vblnk_out (vblnk_out),
        .hcount_out(hcount_out),
        .vcount_out(vcount_out),
        .line_len  (line_len),
        .frame_len (frame_len),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic [3:0]  strb;
        bit          chk;
        logic [11:0] h;
        logic [11:0] v;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int gh = 0;
    int gv = 0;
    int hs_shift = 0;
    bit hold_h = 1'b0;
    bit short_line = 1'b0;
    bit sb_on = 1'b0;
    bit prev_h = 1'b0;
    bit prev_v = 1'b0;
    bit drv_vfall = 1'b0;
    int err_pulses = 0;
    int vfall_count = 0;
    int exp_cnt = 0;

    // Drive one generator pixel, advance the clock, check the scoreboard
    task automatic tick();
        exp_t e;
        int   len;
        @(negedge pclk);
        hblnk_in = hold_h || (gh >= H_ACT);
        vblnk_in = (gv >= V_ACT);
        hsync_in = (gh >= HS_START + hs_shift) && (gh < HS_START + hs_shift + HS_W);
        vsync_in = (gv >= VS_START) && (gv < VS_START + VS_W);
        drv_vfall = prev_v && !vblnk_in;
        if (drv_vfall) vfall_count++;
        if (drv_vfall && prev_h && !hblnk_in) sb_on = 1'b1;
        prev_h = hblnk_in;
        prev_v = vblnk_in;
        e.strb = {hsync_in, vsync_in, hblnk_in, vblnk_in};
        e.chk  = sb_on;
        e.h    = 12'(gh);
        e.v    = 12'(gv);
        sb.push_back(e);
        if (!hold_h) begin
            len = short_line ? H_TOTAL - 1 : H_TOTAL;
            if (gh >= len - 1) begin
                gh = 0;
                short_line = 1'b0;
                gv = (gv == V_TOTAL - 1) ? 0 : gv + 1;
            end else begin
                gh++;
            end
        end
        @(posedge pclk);
        #1;
        if (err) err_pulses++;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== e.strb) begin
                bad++;
                $display("FAIL strobes got %b want %b", {hsync_out, vsync_out, hblnk_out, vblnk_out}, e.strb);
            end
            if (e.chk) begin
                total++;
                if (hcount_out !== e.h || vcount_out !== e.v) begin
                    bad++;
                    $display("FAIL counters got h=%0d v=%0d want h=%0d v=%0d", hcount_out, vcount_out, e.h, e.v);
                end
            end
        end
    endtask

    task automatic wait_lock(input int max_ticks, output bit ok);
        int n = 0;
        while (!locked && n < max_ticks) begin
            tick();
            n++;
        end
        ok = locked;
    endtask

    // Shorten line 0 of the next frame by one pixel; return whether err fired
    task automatic inject_short(output bit seen);
        int n = 0;
        while (!(gv == 0 && gh == 1) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        short_line = 1'b1;
        n = 0;
        while (!err && n < 2 * H_TOTAL) begin
            tick();
            n++;
        end
        seen = err;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        hblnk_in = 1'b1;
        vblnk_in = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        total++;
        if ({hcount_out, vcount_out} !== 24'd0) begin
            bad++;
            $display("FAIL reset_counters got %h want 0", {hcount_out, vcount_out});
        end
        total++;
        if ({line_len, frame_len} !== 24'd0) begin
            bad++;
            $display("FAIL reset_lengths got %h want 0", {line_len, frame_len});
        end
        total++;
        if ({locked, err, err_cnt} !== 10'd0) begin
            bad++;
            $display("FAIL reset_status got %h want 0", {locked, err, err_cnt});
        end
        total++;
        if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== 4'd0) begin
            bad++;
            $display("FAIL reset_strobes got %b want 0000", {hsync_out, vsync_out, hblnk_out, vblnk_out});
        end
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        hblnk_in = 1'b0;
        vblnk_in = 1'b0;
        @(negedge pclk);
        reset_n = 1'b1;
    endtask

    task automatic test_acquire();
        int n = 0;
        int e0;
        vfall_count = 0;
        while (!locked && n < 6 * FRAME) begin
            tick();
            n++;
        end
        total++;
        if (n !== 3 * FRAME + 1) begin
            bad++;
            $display("FAIL lock_cycle got %0d want %0d", n, 3 * FRAME + 1);
        end
        total++;
        if (vfall_count !== LOCK_FRAMES + 1 || !drv_vfall) begin
            bad++;
            $display("FAIL lock_vfalls got %0d (edge=%0d) want %0d", vfall_count, drv_vfall, LOCK_FRAMES + 1);
        end
        total++;
        if (line_len !== 12'(H_TOTAL) || frame_len !== 12'(V_TOTAL)) begin
            bad++;
            $display("FAIL lengths got line=%0d frame=%0d want %0d %0d", line_len, frame_len, H_TOTAL, V_TOTAL);
        end
        total++;
        if (err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL lock_err_cnt got %0d want 0", err_cnt);
        end
        e0 = err_pulses;
        repeat (2 * FRAME) tick();
        total++;
        if (err_pulses !== e0 || locked !== 1'b1) begin
            bad++;
            $display("FAIL stay_locked got errs=%0d locked=%0d want 0 1", err_pulses - e0, locked);
        end
    endtask

    task automatic test_short_line();
        bit seen;
        bit ok;
        int v0;
        inject_short(seen);
        exp_cnt = 1;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL short_err got 0 want 1");
        end
        total++;
        if (line_len !== 12'(H_TOTAL - 1)) begin
            bad++;
            $display("FAIL short_line_len got %0d want %0d", line_len, H_TOTAL - 1);
        end
        total++;
        if (locked !== 1'b0 || err_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL short_status got locked=%0d cnt=%0d want 0 %0d", locked, err_cnt, exp_cnt);
        end
        v0 = vfall_count;
        tick();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_width got %0d want 0", err);
        end
        wait_lock(8 * FRAME, ok);
        total++;
        if (!ok || vfall_count - v0 !== LOCK_FRAMES + 1) begin
            bad++;
            $display("FAIL relock got ok=%0d vfalls=%0d want 1 %0d", ok, vfall_count - v0, LOCK_FRAMES + 1);
        end
    endtask

    task automatic test_watchdog();
        int n = 0;
        int e0;
        bit ok;
        while (!(gh == H_ACT && gv == 0) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        sb_on  = 1'b0;
        hold_h = 1'b1;
        e0 = err_pulses;
        repeat (5000) tick();
        exp_cnt++;
        total++;
        if (hcount_out !== 12'hFFF) begin
            bad++;
            $display("FAIL wdog_hcount got %0d want 4095", hcount_out);
        end
        total++;
        if (err_pulses - e0 !== 1 || locked !== 1'b0) begin
            bad++;
            $display("FAIL wdog_err got errs=%0d locked=%0d want 1 0", err_pulses - e0, locked);
        end
        total++;
        if (err_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL wdog_err_cnt got %0d want %0d", err_cnt, exp_cnt);
        end
        hold_h = 1'b0;
        wait_lock(8 * FRAME, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wdog_relock got 0 want 1");
        end
    endtask

    task automatic test_sync_check();
        int e0;
        int want;
        bit ok;
        e0 = err_pulses;
        hs_shift = 1;
        repeat (FRAME) tick();
        hs_shift = 0;
`ifdef TIMING_DECODER_SYNC_CHECK_EN
        want = 1;
`else
        want = 0;
`endif
        exp_cnt += want;
        total++;
        if (err_pulses - e0 !== want || err_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL sync_check got errs=%0d cnt=%0d want %0d %0d", err_pulses - e0, err_cnt, want, exp_cnt);
        end
        wait_lock(8 * FRAME, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL sync_relock got 0 want 1");
        end
    endtask

    task automatic test_midframe_reset();
        int n = 0;
        int v0;
        bit ok;
        while (!(gv == 1 && gh == 3) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        total++;
        if (locked !== 1'b1 || line_len !== 12'(H_TOTAL)) begin
            bad++;
            $display("FAIL pre_reset got locked=%0d line=%0d want 1 %0d", locked, line_len, H_TOTAL);
        end
        sb_on = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        total++;
        if ({hcount_out, vcount_out, line_len, frame_len} !== 48'd0) begin
            bad++;
            $display("FAIL async_reset_counts got %h want 0", {hcount_out, vcount_out, line_len, frame_len});
        end
        total++;
        if ({locked, err, err_cnt, hsync_out, vsync_out, hblnk_out, vblnk_out} !== 14'd0) begin
            bad++;
            $display("FAIL async_reset_status got %h want 0", {locked, err, err_cnt, hsync_out, vsync_out, hblnk_out, vblnk_out});
        end
        @(negedge pclk);
        reset_n = 1'b1;
        exp_cnt = 0;
        v0 = vfall_count;
        wait_lock(8 * FRAME, ok);
        total++;
        if (!ok || vfall_count - v0 !== LOCK_FRAMES + 1) begin
            bad++;
            $display("FAIL reset_relock got ok=%0d vfalls=%0d want 1 %0d", ok, vfall_count - v0, LOCK_FRAMES + 1);
        end
    endtask

    task automatic test_err_saturation();
        int e0;
        int misses = 0;
        bit ok;
        bit seen;
        e0 = err_pulses;
        for (int i = 0; i < 300; i++) begin
            wait_lock(8 * FRAME, ok);
            if (!ok) begin
                misses++;
                break;
            end
            inject_short(seen);
            if (!seen) misses++;
            exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
            if (i == 99) begin
                total++;
                if (err_cnt !== 8'(exp_cnt)) begin
                    bad++;
                    $display("FAIL err_cnt_mid got %0d want %0d", err_cnt, exp_cnt);
                end
            end
        end
        total++;
        if (misses !== 0) begin
            bad++;
            $display("FAIL sat_injections got misses=%0d want 0", misses);
        end
        total++;
        if (err_cnt !== 8'd255 || err_pulses - e0 !== 300) begin
            bad++;
            $display("FAIL err_cnt_sat got cnt=%0d errs=%0d want 255 300", err_cnt, err_pulses - e0);
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_short_line();
        test_watchdog();
        test_sync_check();
        test_midframe_reset();
        test_err_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
